// File: rtl/cache_data_array.sv
// Set-associative cache data store: WAYS independent 1R1W banks, single-beat writes and a line-fill sequencer.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data into the matching read lane.
//
// state  | meaning
// S_IDLE | no fill active; single-beat writes accepted
// S_FILL | refill line in progress; writes blocked, fill beats stored
module cache_data_array #(
   parameter  int WAYS   = 4,
   parameter  int SETS   = 1024,
   parameter  int BEATS  = 4,
   parameter  int BEAT_W = 128,
   localparam int SET_W  = $clog2(SETS),
   localparam int BI_W   = $clog2(BEATS),
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic [SET_W-1:0]       rd_set,
   input  logic [BI_W-1:0]        rd_beat,
   output logic                   rd_valid,
   output logic [WAYS*BEAT_W-1:0] rd_data,
   input  logic                   wr_en,
   input  logic [WAY_W-1:0]       wr_way,
   input  logic [SET_W-1:0]       wr_set,
   input  logic [BI_W-1:0]        wr_beat,
   input  logic [BEAT_W-1:0]      wr_data,
   output logic                   wr_ready,
   input  logic                   fill_start,
   input  logic [WAY_W-1:0]       fill_way,
   input  logic [SET_W-1:0]       fill_set,
   input  logic                   fill_beat_valid,
   input  logic [BEAT_W-1:0]      fill_data,
   output logic                   fill_busy,
   output logic                   fill_done
);
   localparam int A_W   = SET_W + BI_W;
   localparam int DEPTH = SETS * BEATS;
   localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(BEATS - 1);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t              state_q, state_d;
   logic [BI_W-1:0]     cnt_q, cnt_d;
   logic [WAY_W-1:0]    way_q, way_d;
   logic [SET_W-1:0]    set_q, set_d;
   logic                done_q, done_d;
   logic                rd_valid_q, rd_valid_d;
   logic [WAYS*BEAT_W-1:0] rd_data_q, rd_data_d;

   logic                fill_we;
   logic                wr_ok;
   logic [A_W-1:0]      waddr;
   logic [A_W-1:0]      rd_addr;
   logic [BEAT_W-1:0]   wdata;
   logic [WAYS-1:0]     bank_we;
   logic [WAYS*BEAT_W-1:0] bank_rd;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      way_d   = way_q;
      set_d   = set_q;
      done_d  = 1'b0;
      fill_we = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fill_start) begin
               state_d = S_FILL;
               way_d   = fill_way;
               set_d   = fill_set;
               cnt_d   = '0;
            end
         end
         S_FILL: begin
            if (fill_beat_valid) begin
               fill_we = 1'b1;
               cnt_d   = cnt_q + BI_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wr_ready  = (state_q == S_IDLE);
   assign fill_busy = (state_q == S_FILL);
   assign fill_done = done_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

   // Single writes and fill beats are mutually exclusive, so one shared address/data path serves all banks.
   assign wr_ok   = wr_en && wr_ready;
   assign waddr   = fill_we ? {set_q, cnt_q} : {wr_set, wr_beat};
   assign wdata   = fill_we ? fill_data : wr_data;
   assign rd_addr = {rd_set, rd_beat};

   for (genvar w = 0; w < WAYS; w++) begin : g_bank
      logic [BEAT_W-1:0] mem [DEPTH];

      assign bank_we[w] = (wr_ok && (wr_way == WAY_W'(w))) ||
                          (fill_we && (way_q == WAY_W'(w)));

      always_ff @(posedge clk) begin
         if (bank_we[w]) mem[waddr] <= wdata;
      end

      assign bank_rd[w*BEAT_W +: BEAT_W] = mem[rd_addr];
   end

   always_comb begin
      rd_valid_d = rd_en;
      rd_data_d  = rd_data_q;
      if (rd_en) begin
         rd_data_d = bank_rd;
`ifdef WRITE_BYPASS_EN
         for (int w = 0; w < WAYS; w++) begin
            if (bank_we[w] && (waddr == rd_addr)) rd_data_d[w*BEAT_W +: BEAT_W] = wdata;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         way_q      <= '0;
         set_q      <= '0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         way_q      <= way_d;
         set_q      <= set_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end
endmodule

// File: tb/tb_cache_data_array.sv
// Self-checking bench for cache_data_array: vector table, directed fill/reset sequences, random traffic vs. a model.
module tb_cache_data_array;
   localparam int WAYS = 4, SETS = 1024, BEATS = 4, BEAT_W = 128, DEPTH = SETS * BEATS;
`ifdef WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rd_en, rd_valid, wr_en, wr_ready, fill_start, fill_beat_valid, fill_busy, fill_done;
   logic [9:0] rd_set, wr_set, fill_set;
   logic [1:0] rd_beat, wr_beat, wr_way, fill_way;
   logic [BEAT_W-1:0] wr_data, fill_data;
   logic [WAYS*BEAT_W-1:0] rd_data;

   always #5 clk = ~clk;

   cache_data_array dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_set(rd_set), .rd_beat(rd_beat), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_en(wr_en), .wr_way(wr_way), .wr_set(wr_set), .wr_beat(wr_beat), .wr_data(wr_data),
      .wr_ready(wr_ready),
      .fill_start(fill_start), .fill_way(fill_way), .fill_set(fill_set),
      .fill_beat_valid(fill_beat_valid), .fill_data(fill_data),
      .fill_busy(fill_busy), .fill_done(fill_done)
   );

   int total = 0;
   int bad = 0;

   // reference model: plain memory array plus fill bookkeeping
   logic [BEAT_W-1:0] mdl [WAYS][DEPTH];
   bit                known [WAYS][DEPTH];
   logic [BEAT_W-1:0] exp_lane [WAYS];
   bit                exp_known [WAYS];
   bit exp_valid, m_busy, m_done;
   int m_way, m_set, m_cnt;

   task automatic chk_b(string nm, logic act, logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic chk_w(string nm, logic [511:0] act, logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [BEAT_W-1:0] lane(int w);
      return rd_data[w*BEAT_W +: BEAT_W];
   endfunction

   task automatic idle();
      rd_en = 0; rd_set = 0; rd_beat = 0;
      wr_en = 0; wr_way = 0; wr_set = 0; wr_beat = 0; wr_data = '0;
      fill_start = 0; fill_way = 0; fill_set = 0; fill_beat_valid = 0; fill_data = '0;
   endtask

   // One clock with the currently driven inputs; model predicts, then all outputs are checked.
   task automatic cycle();
      int ra, ww, wad;
      logic [BEAT_W-1:0] wd;
      ww = -1; wad = 0; wd = '0;
      ra = int'(rd_set) * BEATS + int'(rd_beat);
      if (wr_en && !m_busy) begin
         ww = int'(wr_way); wad = int'(wr_set) * BEATS + int'(wr_beat); wd = wr_data;
      end
      if (m_busy && fill_beat_valid) begin
         ww = m_way; wad = m_set * BEATS + m_cnt; wd = fill_data;
      end
      exp_valid = rd_en;
      if (rd_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (BYP && ww == w && wad == ra) begin
               exp_lane[w] = wd; exp_known[w] = 1;
            end else begin
               exp_lane[w] = mdl[w][ra]; exp_known[w] = known[w][ra];
            end
         end
      end
      if (ww >= 0) begin
         mdl[ww][wad] = wd; known[ww][wad] = 1;
      end
      m_done = 0;
      if (!m_busy && fill_start) begin
         m_busy = 1; m_way = int'(fill_way); m_set = int'(fill_set); m_cnt = 0;
      end else if (m_busy && fill_beat_valid) begin
         m_cnt++;
         if (m_cnt == BEATS) begin
            m_busy = 0; m_done = 1;
         end
      end
      @(posedge clk); #1;
      chk_b("rd_valid", rd_valid, exp_valid);
      chk_b("fill_busy", fill_busy, m_busy);
      chk_b("wr_ready", wr_ready, !m_busy);
      chk_b("fill_done", fill_done, m_done);
      for (int w = 0; w < WAYS; w++)
         if (exp_known[w]) chk_w($sformatf("rd_lane%0d", w), 512'(lane(w)), 512'(exp_lane[w]));
   endtask

   task automatic apply_reset();
      rst = 1; #1;
      chk_b("rst_rd_valid", rd_valid, 1'b0);
      chk_w("rst_rd_data", rd_data, 512'h0);
      chk_b("rst_fill_busy", fill_busy, 1'b0);
      chk_b("rst_fill_done", fill_done, 1'b0);
      m_busy = 0; m_done = 0; exp_valid = 0;
      for (int w = 0; w < WAYS; w++) begin
         exp_lane[w] = '0; exp_known[w] = 1;
      end
      #2; rst = 0;
   endtask

   task automatic wr(int w, int s, int b, logic [BEAT_W-1:0] d);
      wr_en = 1; wr_way = 2'(w); wr_set = 10'(s); wr_beat = 2'(b); wr_data = d;
      cycle(); idle();
   endtask

   task automatic rd(int s, int b);
      rd_en = 1; rd_set = 10'(s); rd_beat = 2'(b);
      cycle(); idle();
   endtask

   task automatic fbeat(logic [BEAT_W-1:0] d);
      fill_beat_valid = 1; fill_data = d;
      cycle(); idle();
   endtask

   function automatic logic [BEAT_W-1:0] pat(int w, int b);
      return BEAT_W'(32'h5000 + w * 16 + b);
   endfunction

   typedef struct {
      bit we; int way; int set; int beat; logic [BEAT_W-1:0] wd;
      bit re; int rset; int rbeat;
      bit chk; bit ev; logic [511:0] ed;
   } vec_t;

   vec_t tbl [12];
   logic [BEAT_W-1:0] dv [4];
   logic [BEAT_W-1:0] gv [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1, 0, 5, 2, 128'hA0, 0, 0, 0, 0, 0, 512'h0};
      tbl[1]  = '{1, 1, 5, 2, 128'hA1, 0, 0, 0, 0, 0, 512'h0};
      tbl[2]  = '{1, 2, 5, 2, 128'hA2, 0, 0, 0, 0, 0, 512'h0};
      tbl[3]  = '{1, 3, 5, 2, 128'hA3, 0, 0, 0, 0, 0, 512'h0};
      tbl[4]  = '{0, 0, 0, 0, 128'h0, 1, 5, 2, 1, 1, {128'hA3, 128'hA2, 128'hA1, 128'hA0}};
      tbl[5]  = '{0, 0, 0, 0, 128'h0, 0, 0, 0, 1, 0, {128'hA3, 128'hA2, 128'hA1, 128'hA0}};
      tbl[6]  = '{1, 0, 7, 0, 128'hB0, 0, 0, 0, 0, 0, 512'h0};
      tbl[7]  = '{1, 1, 7, 0, 128'hB1, 0, 0, 0, 0, 0, 512'h0};
      tbl[8]  = '{1, 2, 7, 0, 128'hB2, 0, 0, 0, 0, 0, 512'h0};
      tbl[9]  = '{1, 3, 7, 0, 128'hB3, 0, 0, 0, 0, 0, 512'h0};
      tbl[10] = '{1, 1, 7, 0, 128'hC1, 1, 7, 0, 1, 1,
                  {128'hB3, 128'hB2, (BYP ? 128'hC1 : 128'hB1), 128'hB0}};
      tbl[11] = '{0, 0, 0, 0, 128'h0, 1, 7, 0, 1, 1, {128'hB3, 128'hB2, 128'hC1, 128'hB0}};
      dv = '{128'hD0, 128'hD1, 128'hD2, 128'hD3};
      gv = '{128'h60, 128'h61, 128'h62, 128'h63};
      m_way = 0; m_set = 0; m_cnt = 0;

      idle();
      #1;
      apply_reset();
      chk_b("rst_wr_ready", wr_ready, 1'b1);

      // vector table: writes, 1-cycle read latency, hold on idle, read-during-write
      for (int i = 0; i < 12; i++) begin
         wr_en = tbl[i].we; wr_way = 2'(tbl[i].way); wr_set = 10'(tbl[i].set);
         wr_beat = 2'(tbl[i].beat); wr_data = tbl[i].wd;
         rd_en = tbl[i].re; rd_set = 10'(tbl[i].rset); rd_beat = 2'(tbl[i].rbeat);
         cycle(); idle();
         if (tbl[i].chk) begin
            chk_b($sformatf("vec%0d_valid", i), rd_valid, tbl[i].ev);
            chk_w($sformatf("vec%0d_data", i), rd_data, tbl[i].ed);
         end
      end

      // fill with gaps, blocked write, ignored restart, write in start cycle
      for (int w = 0; w < WAYS; w++)
         for (int b = 0; b < BEATS; b++) wr(w, 1023, b, pat(w, b));
      wr(0, 3, 1, 128'hEEE0 - 128'h10);
      fill_start = 1; fill_way = 2; fill_set = 10'd1023; fill_beat_valid = 1; fill_data = 128'hBAD;
      wr_en = 1; wr_way = 0; wr_set = 10'd3; wr_beat = 1; wr_data = 128'hEEE0;
      cycle(); idle();
      chk_b("fill_start_busy", fill_busy, 1'b1);
      fill_beat_valid = 1; fill_data = dv[0];
      wr_en = 1; wr_way = 0; wr_set = 10'd3; wr_beat = 1; wr_data = 128'hEEE1;
      fill_start = 1; fill_way = 1; fill_set = 10'd0;
      cycle(); idle();
      chk_b("wr_ready_during_fill", wr_ready, 1'b0);
      fbeat(dv[1]);
      cycle(); cycle();
      chk_b("busy_in_gap", fill_busy, 1'b1);
      fbeat(dv[2]);
      fbeat(dv[3]);
      chk_b("fill_done_pulse", fill_done, 1'b1);
      cycle();
      chk_b("fill_done_one_cycle", fill_done, 1'b0);
      for (int b = 0; b < BEATS; b++) begin
         rd(1023, b);
         chk_w($sformatf("fill_lane2_b%0d", b), 512'(lane(2)), 512'(dv[b]));
         chk_w($sformatf("fill_lane0_b%0d", b), 512'(lane(0)), 512'(pat(0, b)));
      end
      rd(3, 1);
      chk_w("wr_in_start_cycle", 512'(lane(0)), 512'(128'hEEE0));

      // back-to-back fills: new start in the fill_done cycle
      fill_start = 1; fill_way = 3; fill_set = 10'd10; cycle(); idle();
      for (int b = 0; b < BEATS; b++) fbeat(dv[b]);
      chk_b("b2b_first_done", fill_done, 1'b1);
      fill_start = 1; fill_way = 0; fill_set = 10'd11; cycle(); idle();
      chk_b("b2b_second_busy", fill_busy, 1'b1);
      for (int b = 0; b < BEATS; b++) fbeat(gv[b]);
      chk_b("b2b_second_done", fill_done, 1'b1);
      for (int b = 0; b < BEATS; b++) begin
         rd(10, b);
         chk_w($sformatf("b2b_s10_b%0d", b), 512'(lane(3)), 512'(dv[b]));
         rd(11, b);
         chk_w($sformatf("b2b_s11_b%0d", b), 512'(lane(0)), 512'(gv[b]));
      end

      // reset after two of four fill beats
      for (int b = 0; b < BEATS; b++) wr(1, 20, b, pat(9, b));
      fill_start = 1; fill_way = 1; fill_set = 10'd20; cycle(); idle();
      fbeat(gv[0]);
      fill_beat_valid = 1; fill_data = gv[1]; rd_en = 1; rd_set = 10'd5; rd_beat = 2;
      cycle(); idle();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         fill_beat_valid = 1; fill_data = 128'hDEAD; cycle(); idle();
         chk_b("no_done_after_abort", fill_done, 1'b0);
      end
      for (int b = 0; b < BEATS; b++) begin
         rd(20, b);
         chk_w($sformatf("abort_b%0d", b), 512'(lane(1)), 512'(b < 2 ? gv[b] : pat(9, b)));
      end

      // random traffic over a small address window
      for (int i = 0; i < 3000; i++) begin
         rd_en = 1'($urandom_range(0, 1)); rd_set = 10'($urandom_range(0, 7));
         rd_beat = 2'($urandom_range(0, 3));
         wr_en = 1'($urandom_range(0, 1)); wr_way = 2'($urandom_range(0, 3));
         wr_set = 10'($urandom_range(0, 7)); wr_beat = 2'($urandom_range(0, 3));
         wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         fill_start = ($urandom_range(0, 7) == 0); fill_way = 2'($urandom_range(0, 3));
         fill_set = 10'($urandom_range(0, 7)); fill_beat_valid = 1'($urandom_range(0, 1));
         fill_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         cycle(); idle();
         if ($urandom_range(0, 499) == 0) apply_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
- Parametrised set-associative cache data store; successor to the fixed 4-way, 128-bit-beat data blockram.
- Holds WAYS x SETS lines of BEATS beats each, BEAT_W bits per beat, as WAYS independent 1R1W banks.
- A single read returns the same beat of one set across all ways, for tag-parallel way select in the cache controller.
- Accepts single-beat writes (store hits) and contains a line-fill sequencer that writes a full refill line beat by beat from the memory interface.

Parameters:
- WAYS, 4, associativity; power of two, >=1.
- SETS, 1024, sets per way; power of two.
- BEATS, 4, beats per cache line; power of two, >=2.
- BEAT_W, 128, bits per beat.
- Derived, not overridable: SET_W=$clog2(SETS), BI_W=$clog2(BEATS), WAY_W=max(1,$clog2(WAYS)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rd_en  in  1  read request.
- rd_set  in  SET_W  read set index.
- rd_beat  in  BI_W  read beat index.
- rd_valid  out  1  rd_data valid, one cycle after rd_en.
- rd_data  out  WAYS*BEAT_W  beat from every way; way w occupies [w*BEAT_W +: BEAT_W].
- wr_en  in  1  single-beat write request.
- wr_way  in  WAY_W  write way.
- wr_set  in  SET_W  write set.
- wr_beat  in  BI_W  write beat.
- wr_data  in  BEAT_W  write data.
- wr_ready  out  1  write accepted when high; equals !fill_busy.
- fill_start  in  1  begin line fill.
- fill_way  in  WAY_W  fill target way, latched on start.
- fill_set  in  SET_W  fill target set, latched on start.
- fill_beat_valid  in  1  fill_data holds the next beat.
- fill_data  in  BEAT_W  fill beat data.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the final fill beat is written.

Behaviour:
- Reset (async, active-high): rd_valid=0, rd_data=0, fill_busy=0, fill_done=0, beat counter=0, FSM=IDLE. Memory contents are not reset and are undefined after power-up.
- Reset mid-fill aborts the fill; beats already written stay in memory. No fill_done is generated.
- Bank addressing: bank w, entry {set, beat}.
- Read: rd_en sampled at edge N; rd_data and rd_valid update at edge N. Latency is 1 cycle.
  - When rd_en=0, rd_valid=0 next cycle and rd_data holds its previous value.
  - Reads are never stalled and may occur every cycle, including during a fill.
- Single write: performed when wr_en && wr_ready; only bank wr_way is written. When wr_ready=0, wr_en is dropped silently and memory is unchanged.
- FSM IDLE:
  - fill_busy=0.
  - fill_start latches way/set, clears counter and moves to FILL.
  - fill_beat_valid in IDLE is ignored, including the fill_start cycle.
  - A write in the fill_start cycle is accepted.
- FSM FILL:
  - fill_busy=1.
  - Each cycle with fill_beat_valid writes fill_data to bank latched_way, entry {latched_set, counter}, then increments counter.
  - Gaps (fill_beat_valid=0) are allowed and write nothing.
  - On the beat with counter==BEATS-1: write it, wrap counter to 0, go to IDLE, assert fill_done for exactly the next cycle.
  - fill_start while in FILL is ignored.
- fill_done cycle: FSM is IDLE and fill_busy=0, so a new fill_start is accepted in the same cycle as fill_done.
- Read-during-write to the same bank/entry in the same cycle returns old data for that way's lane; other lanes are unaffected.

Optional Feature:
- Macro WRITE_BYPASS_EN.
- When defined: for a same-cycle read and write (single-beat write or fill beat) to the same bank/entry, that way's lane of rd_data returns the new write data.
- When undefined: that lane returns old data, as above. Other lanes are unchanged either way.

Test Plan:
- Defaults. Write 128'hA0..A3 to way0..3, set 5, beat 2; read set 5 beat 2 -> one cycle later rd_valid=1, rd_data = {A3,A2,A1,A0} in lanes 3..0.
- fill_start way 2, set 1023; 4 beats D0..D3 with a 2-cycle gap after D1 -> fill_busy high throughout; fill_done pulses exactly 1 cycle after D3; reading beats 0..3 of set 1023 returns D0..D3 in lane 2 and prior contents in other lanes.
- wr_en during FILL -> wr_ready=0, memory unchanged. wr_en in the fill_start cycle -> write lands. fill_start during FILL -> ignored; the original target is still written.
- fill_start asserted in the fill_done cycle -> new fill accepted and fill_busy=1 the next cycle; back-to-back fills both complete.
- Same-cycle read and write to way1 set 7 beat 0, old=X, new=Y -> lane1=X without WRITE_BYPASS_EN, lane1=Y with it.
- Assert rst after 2 of 4 fill beats -> outputs return to reset values at once; beats 0-1 retain new data, beats 2-3 retain old data; fill_done never pulses.
